// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - PC-triggered circular trace buffer for CPU commit records; define TRACE_MEMOUT_EN to also store cpu_memout
module cpu_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int POST  = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [31:0]   cpu_pc,
   input  logic [31:0]   cpu_inst,
   input  logic [31:0]   cpu_aluout,
   input  logic [31:0]   cpu_memout,
   input  logic          arm,
   input  logic [31:0]   trig_pc,
   input  logic          rd_en,
   output logic          rd_valid,
   output logic [31:0]   rd_pc,
   output logic [31:0]   rd_inst,
   output logic [31:0]   rd_aluout,
   output logic [31:0]   rd_memout,
   output logic [1:0]    state,
   output logic [AW:0]   count,
   output logic          triggered
);

`ifdef TRACE_MEMOUT_EN
   localparam int EW = 128;
`else
   localparam int EW = 96;
`endif

   localparam logic [AW:0]   LP_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LP_POST = AW'(POST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_POST = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [AW-1:0]    r_post_rem;
   logic             r_triggered;
   logic             r_rd_valid;
   logic [31:0]      r_rd_pc;
   logic [31:0]      r_rd_inst;
   logic [31:0]      r_rd_aluout;

   logic             w_write;
   logic             w_hit;
   logic             w_read;
   logic             w_rearm;
   logic             w_to_done;
   logic [AW-1:0]    w_wr_ptr_inc;
   logic [AW:0]      w_count_inc;
   logic [EW-1:0]    w_wr_entry;
   logic [EW-1:0]    w_rd_entry;

`ifdef TRACE_MEMOUT_EN
   logic [31:0]      r_rd_memout;
   assign w_wr_entry = {cpu_pc, cpu_inst, cpu_aluout, cpu_memout};
   assign rd_memout  = r_rd_memout;
`else
   logic             w_unused_memout;
   assign w_wr_entry      = {cpu_pc, cpu_inst, cpu_aluout};
   assign rd_memout       = 32'd0;
   assign w_unused_memout = ^cpu_memout;
`endif

   assign w_rd_entry   = r_mem[r_rd_ptr];
   assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
   // Count saturates once the ring is full; older records are then overwritten.
   assign w_count_inc  = (r_count == LP_FULL) ? r_count : r_count + 1'b1;
   assign w_to_done    = (w_next == S_DONE) && (r_state != S_DONE);

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and per-cycle action decode
   always_comb begin
      w_next  = r_state;
      w_write = 1'b0;
      w_hit   = 1'b0;
      w_read  = 1'b0;
      w_rearm = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (arm) begin
               w_next  = S_PRE;
               w_rearm = 1'b1;
            end
         end
         S_PRE: begin
            w_write = 1'b1;
            if (cpu_pc == trig_pc) begin
               w_hit  = 1'b1;
               w_next = (POST == 0) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            w_write = 1'b1;
            if (r_post_rem == AW'(1)) w_next = S_DONE;
         end
         S_DONE: begin
            // arm takes priority over a simultaneous read request
            if (arm) begin
               w_next  = S_PRE;
               w_rearm = 1'b1;
            end else if (rd_en && (r_count != '0)) begin
               w_read = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Record storage; contents survive reset
   always_ff @(posedge clock) begin
      if (w_write && !reset) r_mem[r_wr_ptr] <= w_wr_entry;
   end

   // Pointers, occupancy, trigger bookkeeping and read-back registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_post_rem  <= '0;
         r_triggered <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_pc     <= '0;
         r_rd_inst   <= '0;
         r_rd_aluout <= '0;
`ifdef TRACE_MEMOUT_EN
         r_rd_memout <= '0;
`endif
      end else begin
         r_rd_valid <= 1'b0;
         if (w_rearm) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_triggered <= 1'b0;
         end
         if (w_write) begin
            r_wr_ptr <= w_wr_ptr_inc;
            r_count  <= w_count_inc;
            if (w_hit) begin
               r_triggered <= 1'b1;
               r_post_rem  <= LP_POST;
            end else if (r_state == S_POST) begin
               r_post_rem  <= r_post_rem - 1'b1;
            end
         end
         // Oldest record is at the write pointer once the ring has wrapped, else slot 0
         if (w_to_done) r_rd_ptr <= (w_count_inc == LP_FULL) ? w_wr_ptr_inc : '0;
         if (w_read) begin
            r_rd_valid  <= 1'b1;
            r_rd_pc     <= w_rd_entry[EW-1 -: 32];
            r_rd_inst   <= w_rd_entry[EW-33 -: 32];
            r_rd_aluout <= w_rd_entry[EW-65 -: 32];
`ifdef TRACE_MEMOUT_EN
            r_rd_memout <= w_rd_entry[31:0];
`endif
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_count     <= r_count - 1'b1;
         end
      end
   end

   assign state     = r_state;
   assign count     = r_count;
   assign triggered = r_triggered;
   assign rd_valid  = r_rd_valid;
   assign rd_pc     = r_rd_pc;
   assign rd_inst   = r_rd_inst;
   assign rd_aluout = r_rd_aluout;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - scoreboard bench for cpu_trace_buffer (honours TRACE_MEMOUT_EN)
module tb_cpu_trace_buffer;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int POST  = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   cpu_pc = '0;
   logic [31:0]   cpu_inst = '0;
   logic [31:0]   cpu_aluout = '0;
   logic [31:0]   cpu_memout = '0;
   logic          arm = 1'b0;
   logic [31:0]   trig_pc = '0;
   logic          rd_en = 1'b0;
   logic          rd_valid;
   logic [31:0]   rd_pc;
   logic [31:0]   rd_inst;
   logic [31:0]   rd_aluout;
   logic [31:0]   rd_memout;
   logic [1:0]    state;
   logic [AW:0]   count;
   logic          triggered;

   cpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST(POST)) dut (
      .clock(clock), .reset(reset),
      .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_aluout(cpu_aluout), .cpu_memout(cpu_memout),
      .arm(arm), .trig_pc(trig_pc), .rd_en(rd_en),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_aluout(rd_aluout),
      .rd_memout(rd_memout), .state(state), .count(count), .triggered(triggered)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] alu;
      logic [31:0] mem;
   } rec_t;

   int   n_pass = 0;
   int   n_total = 0;
   rec_t exp_q[$];
   rec_t model[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] trig);
      rec_t r;
      r.pc   = pc;
      r.inst = pc + 32'h1000;
      r.alu  = pc ^ 32'h5A5A_0000;
      r.mem  = (pc == trig) ? 32'hDEAD_BEEF : ~pc;
      return r;
   endfunction

   // Monitor: every presented record must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("rd_pc", rd_pc, e.pc);
            chk("rd_inst", rd_inst, e.inst);
            chk("rd_aluout", rd_aluout, e.alu);
            chk("rd_memout", rd_memout, e.mem);
         end
      end
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_triggered", 32'(triggered), 32'd0);
   endtask

   task automatic pulse_rd_expect_none(input string name);
      @(negedge clock);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      chk(name, 32'(rd_valid), 32'd0);
   endtask

   // Arm, then feed pc=0,4,8,... while capture runs (bounded by stop_n writes)
   task automatic capture(input logic [31:0] trig, input int stop_n, input int exp_n);
      int n;
      rec_t r;
      trig_pc = trig;
      model.delete();
      @(negedge clock);
      arm = 1'b1;
      @(negedge clock);
      arm = 1'b0;
      chk("arm_to_pre", 32'(state), 32'd1);
      n = 0;
      while (state != 2'd3 && n < stop_n) begin
         r = mk(32'(n * 4), trig);
         cpu_pc = r.pc;
         cpu_inst = r.inst;
         cpu_aluout = r.alu;
         cpu_memout = r.mem;
         model.push_back(r);
         if (model.size() > DEPTH) void'(model.pop_front());
         @(negedge clock);
         n++;
         if (r.pc == trig) chk("triggered", 32'(triggered), 32'd1);
      end
      chk("write_count", 32'(n), 32'(exp_n));
   endtask

   task automatic read_n(input int k);
      rec_t e;
      for (int i = 0; i < k; i++) begin
         rd_en = 1'b1;
         e = model.pop_front();
`ifndef TRACE_MEMOUT_EN
         e.mem = 32'd0;
`endif
         exp_q.push_back(e);
         @(negedge clock);
      end
      rd_en = 1'b0;
   endtask

   initial begin
      // 1: reset and idle read
      do_reset();
      pulse_rd_expect_none("idle_rd_valid");

      // 2: trigger at 0x20, ring wraps, 16 records 0x04..0x40
      capture(32'h20, 40, 17);
      chk("t2_state", 32'(state), 32'd3);
      chk("t2_count", 32'(count), 32'd16);
      chk("t2_first_pc_model", model[0].pc, 32'h04);
      read_n(16);
      chk("t2_count_empty", 32'(count), 32'd0);
      pulse_rd_expect_none("t2_rd17_valid");

      // 3: trigger at 0x08, no wrap, 11 records 0x00..0x28
      capture(32'h08, 40, 11);
      chk("t3_state", 32'(state), 32'd3);
      chk("t3_count", 32'(count), 32'd11);
      read_n(11);
      chk("t3_count_empty", 32'(count), 32'd0);

      // 4: reset mid-POST with three writes left
      capture(32'h08, 8, 8);
      chk("t4_state_post", 32'(state), 32'd2);
      do_reset();
      pulse_rd_expect_none("t4_rd_valid");

      // 5: arm beats rd_en in DONE
      capture(32'h08, 40, 11);
      read_n(6);
      chk("t5_count5", 32'(count), 32'd5);
      @(negedge clock);
      arm = 1'b1;
      rd_en = 1'b1;
      @(negedge clock);
      arm = 1'b0;
      rd_en = 1'b0;
      chk("t5_state", 32'(state), 32'd1);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_rd_valid", 32'(rd_valid), 32'd0);
      do_reset();

      // 6: trigger on the first PRE cycle, memout captured on the trigger record
      capture(32'h00, 40, 9);
      chk("t6_state", 32'(state), 32'd3);
      chk("t6_count", 32'(count), 32'd9);
      read_n(1);
      chk("t6_count_after", 32'(count), 32'd8);

      @(negedge clock);
      @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Trace capture block placed directly downstream of the single-cycle CPU top. It consumes the CPU's per-cycle commit outputs (pc, inst, aluout, memout) and records them into a circular buffer. Capture runs until a PC-match trigger fires, then continues for a fixed post-trigger window and freezes. The frozen record set is then drained oldest-first through a simple read handshake, so the bench or a debug port can inspect the instruction history around the trigger.

Parameters:
DEPTH, 16, buffer entries; power of two, >= 2
AW, 4, log2(DEPTH); pointer width
POST, 8, records captured after the trigger record; 0..DEPTH-1

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
cpu_pc  input  32  CPU current PC
cpu_inst  input  32  CPU current instruction
cpu_aluout  input  32  CPU ALU result
cpu_memout  input  32  CPU data-memory read value
arm  input  1  single-cycle pulse; starts or restarts capture
trig_pc  input  32  trigger PC value
rd_en  input  1  request the next record (honoured in DONE only)
rd_valid  output  1  rd_* outputs carry a record this cycle
rd_pc  output  32  read-back pc
rd_inst  output  32  read-back inst
rd_aluout  output  32  read-back aluout
rd_memout  output  32  read-back memout (see Optional Feature)
state  output  2  IDLE=0, PRE=1, POST=2, DONE=3
count  output  AW+1  valid unread entries, 0..DEPTH
triggered  output  1  trigger has fired since the last arm

Behaviour:
- Interface: one clock (clock). reset is synchronous and active-high.
- Reset: state=IDLE; wr_ptr, rd_ptr, count and post_rem = 0; triggered=0; rd_valid=0; all rd_* data = 0. Buffer RAM is not cleared. A reset during any state, including mid-POST, takes effect on that edge.
- IDLE:
  - No writes.
  - arm=1 -> PRE on the next edge. wr_ptr=0, count=0, triggered=0.
- PRE:
  - Every cycle, write {cpu_pc, cpu_inst, cpu_aluout[, cpu_memout]} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count saturates at DEPTH. Oldest entries are overwritten once full.
  - If cpu_pc==trig_pc in the same cycle, that record is still written. triggered<=1 and post_rem<=POST.
    - POST==0 -> DONE.
    - Otherwise -> POST.
  - A match on the first PRE cycle is valid.
- POST:
  - Write every cycle as in PRE. post_rem decrements on each write.
  - The write with post_rem==1 moves the block to DONE.
  - Further PC matches are ignored.
- Entry to DONE: rd_ptr <= (count==DEPTH) ? wr_ptr : 0, i.e. the oldest record. count is the value after the final write.
- DONE:
  - No writes.
  - rd_en=1 with count>0 -> on the next edge: rd_valid=1, rd_* = entry[rd_ptr], rd_ptr++ mod DEPTH, count--. Read latency is one cycle.
  - rd_en=0, or count==0 -> rd_valid=0 on the next edge. rd_* data hold their last value.
  - arm=1 -> PRE on the next edge with wr_ptr=0, count=0, triggered=0, rd_valid=0.
  - arm wins over a simultaneous rd_en.
- arm is ignored in PRE and POST. rd_en is ignored outside DONE, and rd_valid stays 0 there.
- Records are exact copies of the inputs sampled on the write edge. No arithmetic is applied.

Optional Feature:
TRACE_MEMOUT_EN
- Defined:
  - Entries are 128 bits wide and cpu_memout is stored.
  - rd_memout returns the stored value.
- Undefined:
  - Entries are 96 bits wide and cpu_memout is unused.
  - rd_memout is constant 0.
- All other behaviour is identical in both builds.

Test Plan:
(All with DEPTH=16, POST=8.)
1. Assert reset for one edge from any state -> state=0, count=0, rd_valid=0, triggered=0. Then pulse rd_en -> rd_valid stays 0.
2. Pulse arm. From the first PRE cycle drive cpu_pc=0x00, 0x04, ... with trig_pc=0x20.
   - Expect triggered=1 after the 0x20 edge.
   - After 17 writes: DONE with count=16.
   - 16 reads return pc 0x04..0x40 in order; count reaches 0.
   - A 17th rd_en gives rd_valid=0.
3. Same stimulus with trig_pc=0x08.
   - DONE with count=11.
   - Reads return 0x00..0x28.
   - cpu_inst = pc+0x1000 is reproduced on every rd_inst.
4. Pulse reset while state=POST (post_rem=3) -> state=0, count=0, triggered=0. rd_en produces no rd_valid.
5. In DONE with count=5, assert arm and rd_en together -> next cycle state=1, count=0, rd_valid=0.
6. Drive cpu_memout=0xDEADBEEF on the trigger cycle, trig_pc=0x00. Read the first record:
   - With TRACE_MEMOUT_EN: rd_memout=0xDEADBEEF.
   - Without: rd_memout=0.
